// File: rtl/data_mem.sv
// Word-organised data memory for the single-cycle MIPS datapath.
// The ALU result is the effective byte address. Loads are combinational and
// zero-latency. Stores commit on the rising clock edge with byte-lane merging.
// Faulting accesses read as zero and never write.
//
// Ports:
//   clk    rising-edge clock
//   reset  asynchronous active-high; clears every word
//   addr   byte address (ALU result)
//   wdata  store data (rt value); sub-word stores use its low bits
//   we     store request for this cycle
//   width  000 word, 001 half s, 010 half u, 011 byte s, 100 byte u; others illegal
//   pc     PC of the current instruction; used only for the store log
//   rdata  load result, extended to 32 bits; 0 on fault
//   fault  misaligned, out of range, or illegal width (combinational)
module data_mem #(
  parameter int unsigned WORDS = 3072,
  parameter logic [31:0] BASE  = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic        we,
  input  logic [2:0]  width,
  input  logic [31:0] pc,
  output logic [31:0] rdata,
  output logic        fault
);

  localparam int unsigned IW    = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam logic [31:0] BYTES = 32'(4 * WORDS);

  localparam logic [2:0] W_WORD  = 3'b000;
  localparam logic [2:0] W_HALFS = 3'b001;
  localparam logic [2:0] W_HALFU = 3'b010;
  localparam logic [2:0] W_BYTES = 3'b011;
  localparam logic [2:0] W_BYTEU = 3'b100;

  logic [31:0] mem [WORDS];

  logic [31:0]   offset;
  logic [IW-1:0] idx;
  logic          in_range;
  logic          misaligned;
  logic          illegal;
  logic [31:0]   word;
  logic [15:0]   half;
  logic [7:0]    byte_sel;
  logic [3:0]    be;
  logic [31:0]   lane_data;
  logic [31:0]   merged;
  logic          commit;

  // Subtraction wraps addresses below BASE to huge offsets, so one unsigned
  // compare covers both ends of the range.
  assign offset   = addr - BASE;
  assign in_range = offset < BYTES;
  assign idx      = offset[IW+1:2];
  assign word     = in_range ? mem[idx] : 32'h0;
  assign half     = addr[1] ? word[31:16] : word[15:0];
  assign byte_sel = word[8*addr[1:0] +: 8];

  always_comb begin
    misaligned = 1'b0;
    illegal    = 1'b0;
    rdata      = 32'h0;
    be         = 4'b0000;
    lane_data  = wdata;
    case (width)
      W_WORD: begin
        misaligned = addr[1:0] != 2'b00;
        rdata      = word;
        be         = 4'b1111;
      end
      W_HALFS, W_HALFU: begin
        misaligned = addr[0];
        rdata      = (width == W_HALFS) ? {{16{half[15]}}, half} : {16'h0, half};
        be         = addr[1] ? 4'b1100 : 4'b0011;
        lane_data  = {2{wdata[15:0]}};
      end
      W_BYTES, W_BYTEU: begin
        rdata      = (width == W_BYTES) ? {{24{byte_sel[7]}}, byte_sel} : {24'h0, byte_sel};
        be         = 4'b0001 << addr[1:0];
        lane_data  = {4{wdata[7:0]}};
      end
      default: illegal = 1'b1;
    endcase
    fault = !in_range || misaligned || illegal;
    if (fault) begin
      rdata = 32'h0;
    end
  end

  // Read-modify-write: untouched lanes keep the currently stored bytes.
  always_comb begin
    merged = word;
    for (int k = 0; k < 4; k++) begin
      if (be[k]) begin
        merged[8*k +: 8] = lane_data[8*k +: 8];
      end
    end
  end

  assign commit = we && !fault;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < int'(WORDS); i++) begin
        mem[i] <= 32'h0;
      end
    end else if (commit) begin
      mem[idx] <= merged;
    end
  end

`ifndef SYNTHESIS
  // Trace of committed stores for comparison with the reference simulator.
  always @(posedge clk) begin
    if (!reset && commit) begin
      $display("@%08h: *%08h <= %08h", pc, BASE + {offset[31:2], 2'b00}, merged);
    end
  end
`endif

endmodule

// File: tb/tb_data_mem.sv
module tb_data_mem;

  localparam int unsigned WORDS = 3072;
  localparam int unsigned NBYTES = 4 * WORDS;

  logic        clk;
  logic        reset;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        we;
  logic [2:0]  width;
  logic [31:0] pc;
  logic [31:0] rdata;
  logic        fault;

  int errors;
  int checks;

  // Reference model: flat little-endian byte array (BASE = 0).
  logic [7:0] mb [NBYTES];

  data_mem #(.WORDS(WORDS), .BASE(32'h0)) dut (
    .clk   (clk),
    .reset (reset),
    .addr  (addr),
    .wdata (wdata),
    .we    (we),
    .width (width),
    .pc    (pc),
    .rdata (rdata),
    .fault (fault)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic bit ref_fault(input logic [31:0] a, input logic [2:0] w);
    if (a >= NBYTES) return 1'b1;
    if (w > 3'd4) return 1'b1;
    if (w == 3'd0 && a[1:0] != 2'b00) return 1'b1;
    if ((w == 3'd1 || w == 3'd2) && a[0]) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic [31:0] ref_load(input logic [31:0] a, input logic [2:0] w);
    logic [15:0] h;
    logic [7:0]  b;
    if (ref_fault(a, w)) return 32'h0;
    case (w)
      3'd0: return {mb[a+3], mb[a+2], mb[a+1], mb[a]};
      3'd1: begin h = {mb[a+1], mb[a]}; return {{16{h[15]}}, h}; end
      3'd2: begin h = {mb[a+1], mb[a]}; return {16'h0, h}; end
      3'd3: begin b = mb[a]; return {{24{b[7]}}, b}; end
      default: begin b = mb[a]; return {24'h0, b}; end
    endcase
  endfunction

  function automatic void ref_store(input logic [31:0] a, input logic [31:0] d,
                                    input logic [2:0] w);
    int n;
    if (ref_fault(a, w)) return;
    n = (w == 3'd0) ? 4 : ((w <= 3'd2) ? 2 : 1);
    for (int i = 0; i < n; i++) mb[a+i] = d[8*i +: 8];
  endfunction

  function automatic void ref_clear();
    for (int i = 0; i < int'(NBYTES); i++) mb[i] = 8'h0;
  endfunction

  task automatic load(input logic [31:0] a, input logic [2:0] w);
    @(negedge clk);
    we = 1'b0; addr = a; width = w;
    #1;
  endtask

  task automatic store(input logic [31:0] a, input logic [31:0] d, input logic [2:0] w,
                       input logic [31:0] p);
    @(negedge clk);
    addr = a; wdata = d; width = w; pc = p; we = 1'b1;
    @(posedge clk);
    ref_store(a, d, w);
    #1;
    we = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; we = 1'b0; addr = 32'h10; wdata = 32'h0; width = 3'd0; pc = 32'h0;
    ref_clear();
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    load(32'h10, 3'd0);
    checks++;
    if (rdata !== 32'h0) begin
      errors++; $display("FAIL reset_rdata got=%h exp=%h", rdata, 32'h0);
    end
    checks++;
    if (fault !== 1'b0) begin
      errors++; $display("FAIL reset_fault got=%b exp=0", fault);
    end
  endtask

  task automatic test_subword();
    store(32'h10, 32'h1234_5678, 3'd0, 32'h3000);
    load(32'h10, 3'd0);
    checks++;
    if (rdata !== 32'h1234_5678) begin
      errors++; $display("FAIL word_store got=%h exp=%h", rdata, 32'h1234_5678);
    end
    store(32'h13, 32'hFFFF_FFAB, 3'd3, 32'h3004);
    load(32'h10, 3'd0);
    checks++;
    if (rdata !== 32'hAB34_5678) begin
      errors++; $display("FAIL byte_merge got=%h exp=%h", rdata, 32'hAB34_5678);
    end
    load(32'h13, 3'd3);
    checks++;
    if (rdata !== 32'hFFFF_FFAB) begin
      errors++; $display("FAIL byte_signed got=%h exp=%h", rdata, 32'hFFFF_FFAB);
    end
    load(32'h13, 3'd4);
    checks++;
    if (rdata !== 32'h0000_00AB) begin
      errors++; $display("FAIL byte_unsigned got=%h exp=%h", rdata, 32'h0000_00AB);
    end
    store(32'h12, 32'h0000_8001, 3'd1, 32'h3008);
    load(32'h10, 3'd0);
    checks++;
    if (rdata !== 32'h8001_5678) begin
      errors++; $display("FAIL half_merge got=%h exp=%h", rdata, 32'h8001_5678);
    end
    load(32'h12, 3'd1);
    checks++;
    if (rdata !== 32'hFFFF_8001) begin
      errors++; $display("FAIL half_signed got=%h exp=%h", rdata, 32'hFFFF_8001);
    end
    load(32'h12, 3'd2);
    checks++;
    if (rdata !== 32'h0000_8001) begin
      errors++; $display("FAIL half_unsigned got=%h exp=%h", rdata, 32'h0000_8001);
    end
  endtask

  task automatic test_faults();
    logic [31:0] fa [4];
    logic [2:0]  fw [4];
    fa[0] = 32'h22;   fw[0] = 3'd0;
    fa[1] = 32'h15;   fw[1] = 3'd1;
    fa[2] = 32'h3000; fw[2] = 3'd0;
    fa[3] = 32'h10;   fw[3] = 3'd5;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      addr = fa[i]; width = fw[i]; wdata = 32'hDEAD_BEEF; pc = 32'h4000; we = 1'b1;
      #1;
      checks++;
      if (fault !== 1'b1) begin
        errors++; $display("FAIL fault_flag[%0d] got=%b exp=1", i, fault);
      end
      checks++;
      if (rdata !== 32'h0) begin
        errors++; $display("FAIL fault_rdata[%0d] got=%h exp=0", i, rdata);
      end
      @(posedge clk);
      #1;
      we = 1'b0;
    end
    load(32'h10, 3'd0);
    checks++;
    if (rdata !== 32'h8001_5678) begin
      errors++; $display("FAIL fault_nowrite_10 got=%h exp=%h", rdata, 32'h8001_5678);
    end
    load(32'h20, 3'd0);
    checks++;
    if (rdata !== ref_load(32'h20, 3'd0)) begin
      errors++; $display("FAIL fault_nowrite_20 got=%h exp=%h", rdata, ref_load(32'h20, 3'd0));
    end
    load(32'h2FFC, 3'd0);
    checks++;
    if (rdata !== ref_load(32'h2FFC, 3'd0)) begin
      errors++; $display("FAIL fault_nowrite_2ffc got=%h exp=%h", rdata,
                         ref_load(32'h2FFC, 3'd0));
    end
  endtask

  task automatic test_read_during_write();
    store(32'h40, 32'h1, 3'd0, 32'h5000);
    @(negedge clk);
    addr = 32'h40; wdata = 32'h2; width = 3'd0; pc = 32'h5004; we = 1'b1;
    #1;
    checks++;
    if (rdata !== 32'h1) begin
      errors++; $display("FAIL rdw_before got=%h exp=%h", rdata, 32'h1);
    end
    @(posedge clk);
    ref_store(32'h40, 32'h2, 3'd0);
    #1;
    we = 1'b0;
    checks++;
    if (rdata !== 32'h2) begin
      errors++; $display("FAIL rdw_after got=%h exp=%h", rdata, 32'h2);
    end
  endtask

  task automatic test_random();
    logic [31:0] a;
    logic [31:0] d;
    logic [2:0]  w;
    logic        e;
    for (int n = 0; n < 400; n++) begin
      case ($urandom_range(0, 7))
        0:       a = $urandom_range(NBYTES - 8, NBYTES + 8);
        1:       a = $urandom;
        default: a = $urandom_range(0, 63);
      endcase
      w = 3'($urandom_range(0, 5));
      d = $urandom;
      e = 1'($urandom_range(0, 1));
      @(negedge clk);
      addr = a; width = w; wdata = d; we = e; pc = 32'h6000 + 32'(4 * n);
      #1;
      checks++;
      if (fault !== ref_fault(a, w)) begin
        errors++; $display("FAIL rand_fault a=%h w=%0d got=%b exp=%b", a, w, fault,
                           ref_fault(a, w));
      end
      checks++;
      if (rdata !== ref_load(a, w)) begin
        errors++; $display("FAIL rand_rdata a=%h w=%0d got=%h exp=%h", a, w, rdata,
                           ref_load(a, w));
      end
      @(posedge clk);
      if (e) ref_store(a, d, w);
      #1;
      we = 1'b0;
    end
  endtask

  task automatic test_async_reset();
    store(32'h0, 32'hCAFE_0001, 3'd0, 32'h7000);
    store(32'h2FFC, 32'hCAFE_2FFC, 3'd0, 32'h7004);
    load(32'h2FFC, 3'd0);
    checks++;
    if (rdata !== 32'hCAFE_2FFC) begin
      errors++; $display("FAIL top_word got=%h exp=%h", rdata, 32'hCAFE_2FFC);
    end
    @(negedge clk);
    addr = 32'h0; width = 3'd0; wdata = 32'h1111_2222; pc = 32'h7008; we = 1'b1;
    #1;
    reset = 1'b1;
    ref_clear();
    #1;
    checks++;
    if (rdata !== 32'h0) begin
      errors++; $display("FAIL async_reset_0 got=%h exp=0", rdata);
    end
    addr = 32'h2FFC;
    #1;
    checks++;
    if (rdata !== 32'h0) begin
      errors++; $display("FAIL async_reset_2ffc got=%h exp=0", rdata);
    end
    addr = 32'h0;
    @(posedge clk);
    #1;
    @(negedge clk);
    we = 1'b0;
    #1;
    reset = 1'b0;
    load(32'h0, 3'd0);
    checks++;
    if (rdata !== 32'h0) begin
      errors++; $display("FAIL reset_store_dropped got=%h exp=0", rdata);
    end
    load(32'h10, 3'd0);
    checks++;
    if (rdata !== 32'h0) begin
      errors++; $display("FAIL reset_lost_earlier got=%h exp=0", rdata);
    end
  endtask

  initial begin
    errors = 0;
    checks = 0;
    test_reset();
    test_subword();
    test_faults();
    test_read_during_write();
    test_random();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/data_mem.md
Name: data_mem

Overview:
- Word-organised data memory for the single-cycle MIPS datapath.
- Sits directly downstream of the ALU: the ALU result C is the effective address (base + offset) for every load/store, and this block consumes it.
- Supports word, halfword and byte stores with byte-lane merging, and signed/unsigned sub-word loads.
- Flags misaligned and out-of-range accesses and logs every committed store for comparison against the reference simulator.

Parameters:
- WORDS, 3072, number of 32-bit words stored (12 KiB).
- BASE, 32'h0000_0000, byte address of word 0.

Ports:
- clk  input  1  system clock, rising-edge active.
- reset  input  1  asynchronous, active-high; clears all storage.
- addr  input  32  byte address (ALU result).
- wdata  input  32  store data (rt register value).
- we  input  1  store request for this cycle.
- width  input  3  access type: 000 word, 001 half signed, 010 half unsigned, 011 byte signed, 100 byte unsigned; 101-111 illegal.
- pc  input  32  PC of the current instruction, used for logging only.
- rdata  output  32  load result, extended to 32 bits.
- fault  output  1  access is misaligned, out of range, or has an illegal width.

Behaviour:
- Storage: WORDS x 32 array. Offset = addr - BASE; index = offset[31:2].
- Range: access is in range iff offset < 4*WORDS (unsigned compare); wrap-around below BASE counts as out of range.
- Alignment:
  - word requires addr[1:0] == 00.
  - half requires addr[0] == 0.
  - byte is always aligned.
- fault: combinational; 1 when any of out of range, misaligned, or illegal width holds.
- Read path is combinational, zero latency, same cycle as the ALU result.
- Byte lanes are little-endian: lane k = bits [8k+7:8k] and is selected by addr[1:0].
- Load extraction:
  - word: whole word.
  - half: lane pair addr[1] (bits [15:0] when addr[1]=0, [31:16] when addr[1]=1); sign- or zero-extended per width.
  - byte: lane addr[1:0]; sign- or zero-extended per width.
- When fault=1, rdata = 0.
- Store:
  - Commits on rising clk only when we=1, fault=0 and reset=0.
  - Byte enables: word 1111, half 0011 or 1100, byte one-hot at lane addr[1:0].
  - Sub-word stores take data from the low bits of wdata placed into the enabled lanes; non-enabled lanes keep their old contents (read-modify-write inside the block).
  - A store with fault=1 is dropped silently; storage is unchanged and nothing is logged.
- Read-during-write: in the store cycle rdata shows the pre-store contents. The new value is visible after the edge.
- Reset:
  - Asserting reset immediately (asynchronously) clears every word to 0, so rdata reads 0 with no clock edge required.
  - A store coinciding with reset is discarded.
  - Reset mid-sequence loses all earlier stores.
- Logging: on each committed store, print "@<pc>: *<word address> <= <merged 32-bit word>" in 8-digit hex. The word address is BASE + 4*index. Exactly one line per commit.
- Sequential state: the storage array only. No outputs are registered.

Test Plan:
- Reset, then width=000, addr=0x0000_0010 -> rdata=0, fault=0. Store wdata=0x1234_5678 at 0x10 with pc=0x3000 -> after the edge rdata=0x12345678; log "@00003000: *00000010 <= 12345678".
- After the above, store byte 0xAB (wdata=0xFFFF_FFAB, width=011) at 0x13 -> word at 0x10 becomes 0xAB345678. Load width=011 at 0x13 gives 0xFFFF_FFAB; width=100 gives 0x0000_00AB.
- Store half wdata=0x0000_8001 (width=001) at 0x12 -> word = 0x80015678. Load width=001 at 0x12 gives 0xFFFF_8001; width=010 gives 0x0000_8001.
- Alignment/range faults: word store at 0x22, half at 0x15, and word at 0x0000_3000 (=4*WORDS) -> fault=1 in each case, rdata=0, memory unchanged, no log line.
- Read-during-write: word at 0x40 holds 0x1; store 0x2 at 0x40 -> rdata=0x1 until the edge, 0x2 after it.
- Fill 0x0 and 0x2FFC with nonzero values, then assert reset asynchronously between edges -> rdata=0 at both addresses before the next clk edge. A store held with we=1 during reset is not committed and not logged.
